// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive line front end: line states,
// FSM state codes and small counter helpers.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_EOP   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam int unsigned STUFF_LEN_DEFAULT      = 6;
  localparam int unsigned SYNC_MIN_ZEROS_DEFAULT = 3;

  function automatic logic [2:0] sat_inc3(logic [2:0] v);
    return (v == 3'b111) ? v : v + 3'd1;
  endfunction

  // Low-speed devices swap the J/K polarity on the differential pair.
  function automatic line_state_e line_decode(logic dp, logic dm, logic full_speed);
    line_state_e ls;
    case ({dp, dm})
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      2'b10:   ls = full_speed ? LS_J : LS_K;
      default: ls = full_speed ? LS_K : LS_J;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/rx_nrzi_unstuff_if.sv
// Line-side inputs and shifter-side serial outputs of the RX front end.
interface rx_nrzi_unstuff_if;
  logic dp;
  logic dm;
  logic bit_en;
  logic RDI;
  logic RCS;
  logic halt_rx;
  logic rx_eop;
  logic rx_error;

  modport master (output dp, dm, bit_en, input RDI, RCS, halt_rx, rx_eop, rx_error);
  modport slave  (input dp, dm, bit_en, output RDI, RCS, halt_rx, rx_eop, rx_error);
endinterface

// File: rtl/usb_nrzi_dec.sv
// Classifies the dp/dm sample into a line state and NRZI-decodes it
// against the previous J/K level.
module usb_nrzi_dec
  import usb_rx_pkg::*;
#(
  parameter bit FULL_SPEED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_en,
  input  logic        dp,
  input  logic        dm,
  output line_state_e line_st,
  output logic        dec_bit
);

  logic prev_k_q, prev_k_d;

  always_comb begin
    line_st  = line_decode(dp, dm, FULL_SPEED);
    dec_bit  = 1'b1;
    prev_k_d = prev_k_q;
    // SE0/SE1 carry no data and leave the reference level untouched.
    if (line_st == LS_J || line_st == LS_K) begin
      dec_bit = ((line_st == LS_K) == prev_k_q);
      if (bit_en) prev_k_d = (line_st == LS_K);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) prev_k_q <= 1'b0;
    else       prev_k_q <= prev_k_d;
  end

endmodule

// File: rtl/rx_nrzi_unstuff.sv
// RX line front end: SYNC hunt, bit unstuffing and EOP detection feeding
// the serial-to-parallel shifter through RDI/RCS/halt_rx.
module rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter bit          FULL_SPEED     = 1'b1,
  parameter int unsigned SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEFAULT,
  parameter int unsigned STUFF_LEN      = STUFF_LEN_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  rx_nrzi_unstuff_if.slave  bus
);

  line_state_e line_st;
  logic        dec_bit;

  usb_nrzi_dec #(.FULL_SPEED(FULL_SPEED)) u_dec (
    .clock   (clock),
    .reset   (reset),
    .bit_en  (bus.bit_en),
    .dp      (bus.dp),
    .dm      (bus.dm),
    .line_st (line_st),
    .dec_bit (dec_bit)
  );

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;        // SYNC zero count, or J run length in ABORT
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       armed_q, armed_d;
  logic       rdi_q, rdi_d;
  logic       rcs_q, rcs_d;
  logic       halt_q, halt_d;
  logic       eop_q, eop_d;
  logic       err_q, err_d;
  logic       go_abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    bit_cnt_d = bit_cnt_q;
    armed_d   = armed_q;
    rdi_d     = rdi_q;
    rcs_d     = rcs_q;
    halt_d    = rcs_q;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    go_abort  = 1'b0;

    if (bus.bit_en) begin
      halt_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (line_st == LS_K && !dec_bit) begin
            state_d = ST_SYNC;
            cnt_d   = 3'd1;
          end
        end
        ST_SYNC: begin
          case (line_st)
            LS_J, LS_K: begin
              if (!dec_bit) begin
                cnt_d = sat_inc3(cnt_q);
              end else if (cnt_q >= 3'(SYNC_MIN_ZEROS)) begin
                state_d   = ST_DATA;
                ones_d    = 3'd1;
                bit_cnt_d = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end
            LS_SE0:  state_d = ST_IDLE;
            default: go_abort = 1'b1;
          endcase
        end
        ST_DATA: begin
          case (line_st)
            LS_J, LS_K: begin
              if (ones_q == 3'(STUFF_LEN)) begin
                if (!dec_bit) begin
                  halt_d = 1'b1;
                  ones_d = '0;
                end else begin
                  go_abort = 1'b1;
                end
              end else begin
                rdi_d     = dec_bit;
                rcs_d     = 1'b1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                ones_d    = dec_bit ? sat_inc3(ones_q) : 3'd0;
              end
            end
            LS_SE0: begin
              rcs_d   = 1'b0;
              state_d = ST_EOP;
              armed_d = 1'b0;
            end
            default: go_abort = 1'b1;
          endcase
        end
        ST_EOP: begin
          case (line_st)
            LS_SE0: armed_d = 1'b1;
            LS_J: begin
              if (armed_q) begin
                eop_d   = 1'b1;
                err_d   = (bit_cnt_q != 3'd0);
                state_d = ST_IDLE;
              end else begin
                go_abort = 1'b1;
              end
            end
            default: go_abort = 1'b1;
          endcase
        end
        ST_ABORT: begin
          // Leave on SE0 then J, or on eight J samples in a row.
          case (line_st)
            LS_SE0: begin
              armed_d = 1'b1;
              cnt_d   = '0;
            end
            LS_J: begin
              if (armed_q || cnt_q == 3'd7) state_d = ST_IDLE;
              else                          cnt_d   = cnt_q + 3'd1;
            end
            default: begin
              armed_d = 1'b0;
              cnt_d   = '0;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase

      if (go_abort) begin
        err_d   = 1'b1;
        rcs_d   = 1'b0;
        halt_d  = 1'b0;
        state_d = ST_ABORT;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      armed_q   <= 1'b0;
      rdi_q     <= 1'b0;
      rcs_q     <= 1'b0;
      halt_q    <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      armed_q   <= armed_d;
      rdi_q     <= rdi_d;
      rcs_q     <= rcs_d;
      halt_q    <= halt_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
    end
  end

  assign bus.RDI      = rdi_q;
  assign bus.RCS      = rcs_q;
  assign bus.halt_rx  = halt_q;
  assign bus.rx_eop   = eop_q;
  assign bus.rx_error = err_q;

endmodule
